regfile_wb_arbiter: RTL

//  Shares the single register-file write port between two sources.
//  A: the in-order pipeline WB stage. B: a long-latency unit (mul/div/load-miss) using valid/ready.
//  B results are buffered in a small FIFO. A pending-write scoreboard flags RAW/WAW hazards to ID.

---
 rtl/regfile_wb_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the single register-file write port between two sources:
//   A - the in-order pipeline WB stage (plain write request, same-cycle).
//   B - a long-latency unit (mul/div/load-miss) using a valid/ready handshake.
// B results are buffered in a small FIFO. A is normally preferred. A
// starvation counter forces the FIFO head through after STARVE_MAX lost
// cycles. A pending-write scoreboard flags RAW/WAW hazards back to ID.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   a_we_i/a_addr_i/a_data_i     pipeline WB write request
//   b_valid_i/b_ready_o          long-latency result handshake
//   b_addr_i/b_data_i            long-latency result payload
//   iss_valid_i/iss_rd_i         long-latency op issued, with its destination
//   id_rs_i/id_rt_i              ID-stage sources (RAW check)
//   id_rd_i/id_rd_en_i           ID-stage destination (WAW check)
//   hazard_o                     ID must stall
//   stall_o                      pipeline must hold WB this cycle
//   RegWrite_o/RDaddr_o/RDdata_o register-file write port
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              a_we_i,
   input  logic [ADDR_W-1:0] a_addr_i,
   input  logic [DATA_W-1:0] a_data_i,
   input  logic              b_valid_i,
   output logic              b_ready_o,
   input  logic [ADDR_W-1:0] b_addr_i,
   input  logic [DATA_W-1:0] b_data_i,
   input  logic              iss_valid_i,
   input  logic [ADDR_W-1:0] iss_rd_i,
   input  logic [ADDR_W-1:0] id_rs_i,
   input  logic [ADDR_W-1:0] id_rt_i,
   input  logic [ADDR_W-1:0] id_rd_i,
   input  logic              id_rd_en_i,
   output logic              hazard_o,
   output logic              stall_o,
   output logic              RegWrite_o,
   output logic [ADDR_W-1:0] RDaddr_o,
   output logic [DATA_W-1:0] RDdata_o
);

   localparam int NUM_REGS = 2 ** ADDR_W;
   localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
   localparam int STARVE_W = $clog2(STARVE_MAX + 1);

   localparam logic [CNT_W-1:0]    FULL_CNT   = CNT_W'(FIFO_DEPTH);
   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
   localparam logic [NUM_REGS-1:0] REG0_BIT   = NUM_REGS'(1);

   // FIFO storage and bookkeeping
   logic [ADDR_W-1:0]   fifo_addr_r [FIFO_DEPTH];
   logic [DATA_W-1:0]   fifo_data_r [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_r;
   logic [PTR_W-1:0]    rd_ptr_r;
   logic [CNT_W-1:0]    count_r;
   logic                empty_s;
   logic                full_s;
   logic                enq_s;
   logic [ADDR_W-1:0]   head_addr_s;
   logic [DATA_W-1:0]   head_data_s;

   // Arbitration
   logic [STARVE_W-1:0] starve_cnt_r;
   logic                stall_s;
   logic                a_grant_s;
   logic                b_grant_s;

   // Scoreboard
   logic [NUM_REGS-1:0] pend_r;
   logic [NUM_REGS-1:0] pend_nxt_s;
   logic [NUM_REGS-1:0] set_mask_s;
   logic [NUM_REGS-1:0] clr_mask_s;
   logic                iss_set_s;

   assign empty_s     = (count_r == {CNT_W{1'b0}});
   assign full_s      = (count_r == FULL_CNT);
   // Ready comes purely from the registered count, so a full FIFO never
   // accepts even when the head is leaving this cycle.
   assign b_ready_o   = ~full_s;
   assign enq_s       = b_valid_i & ~full_s;
   assign head_addr_s = fifo_addr_r[rd_ptr_r];
   assign head_data_s = fifo_data_r[rd_ptr_r];

   // Grant selection: A preferred unless the starvation limit has been reached
   always_comb begin
      stall_s   = 1'b0;
      a_grant_s = 1'b0;
      b_grant_s = 1'b0;
      if (rst_i) begin
         // Nothing is granted while reset is held.
         stall_s = 1'b0;
      end else begin
         stall_s = (starve_cnt_r >= STARVE_LIM);
         if (stall_s) begin
            // a_we_i during stall is a protocol violation and is ignored.
            b_grant_s = ~empty_s;
         end else if (a_we_i) begin
            a_grant_s = 1'b1;
         end else begin
            b_grant_s = ~empty_s;
         end
      end
   end

   assign stall_o = stall_s;

   // Register-file port drive; writes to r0 are suppressed but still consume a B entry
   always_comb begin
      RegWrite_o = 1'b0;
      RDaddr_o   = {ADDR_W{1'b0}};
      RDdata_o   = {DATA_W{1'b0}};
      if (a_grant_s) begin
         RegWrite_o = (a_addr_i != {ADDR_W{1'b0}});
         RDaddr_o   = a_addr_i;
         RDdata_o   = a_data_i;
      end else if (b_grant_s) begin
         RegWrite_o = (head_addr_s != {ADDR_W{1'b0}});
         RDaddr_o   = head_addr_s;
         RDdata_o   = head_data_s;
      end else begin
         RegWrite_o = 1'b0;
      end
   end

   // FIFO payload storage; contents are only observed while the entry is counted
   always_ff @(posedge clk_i) begin
      if (enq_s && !rst_i) begin
         fifo_addr_r[wr_ptr_r] <= b_addr_i;
         fifo_data_r[wr_ptr_r] <= b_data_i;
      end
   end

   // FIFO pointers and occupancy; power-of-two depth makes pointer wrap natural
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (enq_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (b_grant_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({enq_s, b_grant_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Starvation counter: counts cycles the waiting head loses to A
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         starve_cnt_r <= {STARVE_W{1'b0}};
      end else if (empty_s || b_grant_s) begin
         starve_cnt_r <= {STARVE_W{1'b0}};
      end else if (a_grant_s && (starve_cnt_r < STARVE_LIM)) begin
         starve_cnt_r <= starve_cnt_r + STARVE_W'(1);
      end else begin
         starve_cnt_r <= starve_cnt_r;
      end
   end

   // Set on issue, clear when the head retires; set is applied last so it wins
   assign iss_set_s  = iss_valid_i & (iss_rd_i != {ADDR_W{1'b0}});
   assign set_mask_s = iss_set_s ? (REG0_BIT << iss_rd_i) : {NUM_REGS{1'b0}};
   assign clr_mask_s = b_grant_s ? (REG0_BIT << head_addr_s) : {NUM_REGS{1'b0}};
   assign pend_nxt_s = ((pend_r & ~clr_mask_s) | set_mask_s) & ~REG0_BIT;

   // Scoreboard register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pend_r <= {NUM_REGS{1'b0}};
      end else begin
         pend_r <= pend_nxt_s;
      end
   end

   // The issue term covers a dependent op sitting in ID in the issue cycle
   // itself, before the scoreboard bit is visible. r0 never carries a hazard.
   assign hazard_o = pend_r[id_rs_i] | pend_r[id_rt_i]
                   | (id_rd_en_i & pend_r[id_rd_i])
                   | (iss_set_s & ((iss_rd_i == id_rs_i) | (iss_rd_i == id_rt_i)));

endmodule
